// File: rtl/serdes_pkg.sv
// serdes_pkg: shared constants and types for the 6b serializer stage.
//   SYM_W     - coded symbol width (6b after 5B/6B encoding)
//   IDLE_SYM  - disparity-neutral filler symbol, sent bit 0 first (1,1,1,0,0,0)
//   LAST_BIT  - bit counter value while the final symbol bit is on the line
//   state_t   - serializer FSM states
package serdes_pkg;

   localparam int SYM_W     = 6;
   localparam int BIT_CNT_W = 3;

   localparam logic [SYM_W-1:0]     IDLE_SYM = 6'b000111;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'(SYM_W - 1);

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: synchronous first-word-fall-through FIFO for coded symbols.
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, empties the FIFO
//   wr_en    - write request; ignored while full
//   wr_data  - data written on an accepted write
//   rd_en    - read (pop) request; ignored while empty
//   rd_data  - head entry, valid whenever empty is low
//   full     - count == DEPTH
//   empty    - count == 0
//   count    - registered occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sym_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/serializer_6b.sv
// serializer_6b: buffers 6b coded symbols and shifts them out LSB first.
//   i_clk        - system clock, rising edge
//   i_rst        - asynchronous active-low reset
//   i_data_in    - coded symbol, bit 0 transmitted first
//   i_valid      - i_data_in valid
//   o_ready      - FIFO can accept a symbol this cycle
//   o_ser        - serial bit, registered
//   o_ser_valid  - o_ser carries symbol/idle data, registered
//   o_sym_start  - o_ser carries bit 0 of a symbol
//   o_underrun   - one-cycle pulse: symbol boundary hit with FIFO empty
// Build option: SERIALIZER_IDLE_INSERT_EN - on underrun transmit IDLE_SYM
// instead of returning the line to quiet.
//
// state    | meaning
// ST_WAIT  | line quiet, waiting for a buffered symbol
// ST_SHIFT | symbol in shift register, one bit per clock on o_ser
module serializer_6b
   import serdes_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [SYM_W-1:0] i_data_in,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_ser,
   output logic             o_ser_valid,
   output logic             o_sym_start,
   output logic             o_underrun
);

   state_t                 state_q, state_d;
   logic [SYM_W-1:0]       sh_q, sh_d;
   logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   ser_valid_q, ser_valid_d;
   logic                   sym_start_q, sym_start_d;
   logic                   underrun_q, underrun_d;
   logic                   rdy_en_q;
   logic                   pop;

   logic [SYM_W-1:0]       fifo_rd_data;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic                   unused_fifo_count;

   // Occupancy is already summarised by full/empty.
   assign unused_fifo_count = ^fifo_count;

   // Keeps o_ready low during reset and until the first edge after release.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) rdy_en_q <= 1'b0;
      else        rdy_en_q <= 1'b1;
   end

   assign o_ready = rdy_en_q && !fifo_full;

   sym_fifo #(
      .WIDTH (SYM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst),
      .wr_en   (i_valid && o_ready),
      .wr_data (i_data_in),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_WAIT;
         sh_q        <= '0;
         cnt_q       <= '0;
         ser_valid_q <= 1'b0;
         sym_start_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         ser_valid_q <= ser_valid_d;
         sym_start_q <= sym_start_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      ser_valid_d = ser_valid_q;
      sym_start_d = 1'b0;
      underrun_d  = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               sh_d        = fifo_rd_data;
               ser_valid_d = 1'b1;
               sym_start_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_SHIFT;
            end else begin
               sh_d        = '0;
               ser_valid_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != LAST_BIT) begin
               sh_d  = sh_q >> 1;
               cnt_d = cnt_q + BIT_CNT_W'(1);
            end else if (!fifo_empty) begin
               // Back-to-back: next symbol follows with no gap bit.
               pop         = 1'b1;
               sh_d        = fifo_rd_data;
               sym_start_d = 1'b1;
               cnt_d       = '0;
            end else begin
               underrun_d = 1'b1;
`ifdef SERIALIZER_IDLE_INSERT_EN
               sh_d        = IDLE_SYM;
               sym_start_d = 1'b1;
               cnt_d       = '0;
`else
               sh_d        = '0;
               ser_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = ST_WAIT;
`endif
            end
         end
         default: begin
            state_d     = ST_WAIT;
            sh_d        = '0;
            ser_valid_d = 1'b0;
            cnt_d       = '0;
         end
      endcase
   end

   assign o_ser       = sh_q[0];
   assign o_ser_valid = ser_valid_q;
   assign o_sym_start = sym_start_q;
   assign o_underrun  = underrun_q;

endmodule
